// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: round-robin arbitration of the register-file write port, a registered
// write toward the register file, and a per-register busy scoreboard for decode hazard checks.
module regfile_wb_scheduler #(
    parameter int unsigned REGISTER_WIDTH   = 64,
    parameter int unsigned REGISTERNO_WIDTH = 5,
    parameter int unsigned NUM_REQ          = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*REGISTERNO_WIDTH-1:0]  req_regno,
    input  logic [NUM_REQ*REGISTER_WIDTH-1:0]    req_value,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic                                 out_wr_enable,
    output logic [REGISTERNO_WIDTH-1:0]          out_rd_regno,
    output logic [REGISTER_WIDTH-1:0]            out_rd_value,
    input  logic                                 reserve_valid,
    input  logic [REGISTERNO_WIDTH-1:0]          reserve_regno,
    output logic                                 reserve_ready,
    input  logic [REGISTERNO_WIDTH-1:0]          chk_rs1_regno,
    input  logic [REGISTERNO_WIDTH-1:0]          chk_rs2_regno,
    output logic                                 stall,
    output logic [(1<<REGISTERNO_WIDTH)-1:0]     busy_vector
);

    localparam int unsigned IdxW    = $clog2(NUM_REQ);
    localparam int unsigned NumRegs = 1 << REGISTERNO_WIDTH;

    logic [IdxW-1:0]             last_q, last_d;
    logic                        wr_en_q, wr_en_d;
    logic [REGISTERNO_WIDTH-1:0] regno_q, regno_d;
    logic [REGISTER_WIDTH-1:0]   value_q, value_d;
    logic [NumRegs-1:0]          busy_q, busy_d;

    logic [IdxW-1:0]             grant_idx;
    logic [IdxW-1:0]             idx;
    logic                        grant_any;
    logic [REGISTERNO_WIDTH-1:0] sel_regno;
    logic [REGISTER_WIDTH-1:0]   sel_value;

    // Search starts just after the last winner, so the previous winner ranks lowest.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        req_ready = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = IdxW'((32'(last_q) + k) % NUM_REQ);
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign sel_regno = req_regno[grant_idx*REGISTERNO_WIDTH +: REGISTERNO_WIDTH];
    assign sel_value = req_value[grant_idx*REGISTER_WIDTH +: REGISTER_WIDTH];

    assign reserve_ready = (reserve_regno == '0) || !busy_q[reserve_regno];
    assign stall = ((chk_rs1_regno != '0) && busy_q[chk_rs1_regno]) ||
                   ((chk_rs2_regno != '0) && busy_q[chk_rs2_regno]);

    always_comb begin
        last_d  = last_q;
        wr_en_d = 1'b0;
        regno_d = regno_q;
        value_d = value_q;
        if (grant_any) begin
            last_d = grant_idx;
            // x0 grants complete the handshake but never reach the register file
            if (sel_regno != '0) begin
                wr_en_d = 1'b1;
                regno_d = sel_regno;
                value_d = sel_value;
            end
        end

        busy_d = busy_q;
        if (wr_en_q) begin
            busy_d[regno_q] = 1'b0;
        end
        if (reserve_valid && reserve_ready && (reserve_regno != '0)) begin
            busy_d[reserve_regno] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q  <= IdxW'(NUM_REQ - 1);
            wr_en_q <= 1'b0;
            regno_q <= '0;
            value_q <= '0;
            busy_q  <= '0;
        end else begin
            last_q  <= last_d;
            wr_en_q <= wr_en_d;
            regno_q <= regno_d;
            value_q <= value_d;
            busy_q  <= busy_d;
        end
    end

    assign out_wr_enable = wr_en_q;
    assign out_rd_regno  = regno_q;
    assign out_rd_value  = value_q;
    assign busy_vector   = busy_q;

endmodule
